// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the byte-stream program loader: word/byte widths and
// the loader state encoding. No ports.
package imem_loader_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;

   // StCheck is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLen   = 3'd1,
      StLoad  = 3'd2,
      StWrite = 3'd3,
      StCheck = 3'd4,
      StDone  = 3'd5,
      StError = 3'd6
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Bundles the incoming byte stream handshake and the instruction-memory write
// port of the loader.
//   byte_in/byte_valid  : byte source -> loader
//   byte_ready          : loader -> byte source
//   imem_wr_en/addr/data: loader -> instruction memory
// Modports: master = loader side, slave = byte source / memory side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
);

   logic [BYTE_W-1:0] byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              imem_wr_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wr_data;

   modport master (
      input  byte_in,
      input  byte_valid,
      output byte_ready,
      output imem_wr_en,
      output imem_addr,
      output imem_wr_data
   );

   modport slave (
      output byte_in,
      output byte_valid,
      input  byte_ready,
      input  imem_wr_en,
      input  imem_addr,
      input  imem_wr_data
   );

endinterface

// File: rtl/imem_word_assembler.sv
// imem_word_assembler
// Big-endian byte-to-word assembler: a 2-bit lane counter plus a 24-bit shift
// register holding the first three bytes of the current word.
//   clk, rst       : clock, asynchronous active-high reset
//   i_byte         : incoming byte
//   i_accept       : byte is accepted this cycle
//   o_word         : assembled word, valid together with o_word_valid
//   o_word_valid   : the accepted byte completes a word (lane 3)
// o_word/o_word_valid are combinational so the caller can register the word on
// the same edge that accepts its last byte.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] i_byte,
   input  logic              i_accept,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_valid
);

   logic [1:0]               r_lane;
   logic [WORD_W-BYTE_W-1:0] r_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lane  <= 2'd0;
         r_shift <= '0;
      end else if (i_accept) begin
         r_lane  <= r_lane + 2'd1;  // wraps 3 -> 0
         r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
      end
   end

   assign o_word       = {r_shift, i_byte};
   assign o_word_valid = i_accept && (r_lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Byte-stream program loader. Receives a big-endian 32-bit word count N followed
// by N big-endian instruction words, writes them to instruction memory at word
// addresses 0..N-1 and holds the processor in start-up until the load completes.
//   clk           : system clock, rising edge
//   start_up      : asynchronous active-high reset
//   bus           : imem_loader_if.master (byte handshake + imem write port)
//   cpu_start_up  : processor start_up, high holds the PC at 0
//   busy          : length or data bytes being received
//   done          : program resident, processor released
//   error         : malformed stream, processor stays held
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: after the Nth word a
// big-endian checksum word must equal the XOR of all data words.
// MAX_WORDS must not exceed 2**ADDR_W, so the write address never wraps.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic          clk,
   input  logic          start_up,
   imem_loader_if.master bus,
   output logic          cpu_start_up,
   output logic          busy,
   output logic          done,
   output logic          error
);

   logic              w_accept;
   logic              w_word_valid;
   logic [WORD_W-1:0] w_word;
   logic [ADDR_W:0]   w_idx_inc;

   state_e            r_state;
   logic              r_byte_ready;
   logic              r_wr_en;
   logic [WORD_W-1:0] r_wr_data;
   logic [ADDR_W:0]   r_idx;   // one extra bit so it can reach N == 2**ADDR_W
   logic [ADDR_W:0]   r_len;
   logic              r_cpu_start_up;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] r_csum;
`endif

   assign w_accept  = bus.byte_valid && r_byte_ready;
   assign w_idx_inc = r_idx + (ADDR_W + 1)'(1);

   imem_word_assembler u_assembler (
      .clk          (clk),
      .rst          (start_up),
      .i_byte       (bus.byte_in),
      .i_accept     (w_accept),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // Every output is a register updated alongside the state, so each transition
   // also sets the output values of the state being entered.
   always_ff @(posedge clk or posedge start_up) begin
      if (start_up) begin
         r_state        <= StIdle;
         r_byte_ready   <= 1'b0;
         r_wr_en        <= 1'b0;
         r_wr_data      <= '0;
         r_idx          <= '0;
         r_len          <= '0;
         r_cpu_start_up <= 1'b1;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum         <= '0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            StIdle: begin
               r_byte_ready <= 1'b1;
               if (w_accept) begin
                  r_state <= StLen;
                  r_busy  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum  <= '0;
`endif
               end
            end

            StLen: begin
               if (w_word_valid) begin
                  if (w_word == '0) begin
                     r_state        <= StDone;
                     r_byte_ready   <= 1'b0;
                     r_busy         <= 1'b0;
                     r_done         <= 1'b1;
                     r_cpu_start_up <= 1'b0;
                  end else if (w_word > MAX_WORDS) begin
                     // Compared at full width: large counts are rejected, not truncated.
                     r_state      <= StError;
                     r_byte_ready <= 1'b0;
                     r_busy       <= 1'b0;
                     r_error      <= 1'b1;
                  end else begin
                     r_state <= StLoad;
                     r_len   <= w_word[ADDR_W:0];
                  end
               end
            end

            StLoad: begin
               if (w_word_valid) begin
                  r_state      <= StWrite;
                  r_byte_ready <= 1'b0;
                  r_busy       <= 1'b0;
                  r_wr_en      <= 1'b1;
                  r_wr_data    <= w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum       <= r_csum ^ w_word;
`endif
               end
            end

            StWrite: begin
               r_idx <= w_idx_inc;
               if (w_idx_inc == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state        <= StCheck;
                  r_byte_ready   <= 1'b1;
`else
                  r_state        <= StDone;
                  r_done         <= 1'b1;
                  r_cpu_start_up <= 1'b0;
`endif
               end else begin
                  r_state      <= StLoad;
                  r_byte_ready <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            StCheck: begin
               if (w_word_valid) begin
                  r_byte_ready <= 1'b0;
                  if (w_word == r_csum) begin
                     r_state        <= StDone;
                     r_done         <= 1'b1;
                     r_cpu_start_up <= 1'b0;
                  end else begin
                     r_state <= StError;
                     r_error <= 1'b1;
                  end
               end
            end
`endif

            StDone: begin
               r_state <= StDone;
            end

            StError: begin
               r_state <= StError;
            end

            // Unused encodings fail safe: processor stays held.
            default: begin
               r_state        <= StError;
               r_byte_ready   <= 1'b0;
               r_busy         <= 1'b0;
               r_error        <= 1'b1;
               r_cpu_start_up <= 1'b1;
            end
         endcase
      end
   end

   assign bus.byte_ready   = r_byte_ready;
   assign bus.imem_wr_en   = r_wr_en;
   assign bus.imem_addr    = r_idx[ADDR_W-1:0];
   assign bus.imem_wr_data = r_wr_data;
   assign cpu_start_up     = r_cpu_start_up;
   assign busy             = r_busy;
   assign done             = r_done;
   assign error            = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. Byte streams are built as byte queues;
// expected writes and final status come from a stream-level model that parses
// the byte queue (length, words, optional checksum) directly.
module tb_imem_loader;

   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned MAX_WORDS = 1024;

   logic clk = 1'b0;
   logic start_up;
   logic cpu_start_up, busy, done, error;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(
      .ADDR_W    (ADDR_W),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk          (clk),
      .start_up     (start_up),
      .bus          (bus),
      .cpu_start_up (cpu_start_up),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Stimulus and model state
   logic [7:0]        stim[$];
   int                exp_addr[$];
   logic [31:0]       exp_data[$];
   bit                exp_done, exp_error;

   // Observed writes
   logic [ADDR_W-1:0] got_addr[$];
   logic [31:0]       got_data[$];
   int                got_cyc[$];
   bit                got_lat[$];

   int cyc = 0;
   int hs_cnt = 0;
   int last4_cyc = -10;

   always @(posedge clk) cyc <= cyc + 1;

   // Records every write and whether it came exactly one cycle after the
   // handshake of a 4th byte.
   always @(negedge clk) begin
      if (start_up) begin
         hs_cnt = 0;
      end else begin
         if (bus.imem_wr_en) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wr_data);
            got_cyc.push_back(cyc);
            got_lat.push_back(cyc == last4_cyc + 1);
         end
         if (bus.byte_valid && bus.byte_ready) begin
            hs_cnt++;
            if (hs_cnt % 4 == 0) last4_cyc = cyc;
         end
      end
   end

   task automatic add_word(input logic [31:0] w);
      stim.push_back(w[31:24]);
      stim.push_back(w[23:16]);
      stim.push_back(w[15:8]);
      stim.push_back(w[7:0]);
   endtask

   // Random program of n words, terminated by a correct checksum when enabled.
   task automatic build_program(input int n);
      logic [31:0] w;
      logic [31:0] x;
      x = '0;
      stim.delete();
      add_word(n);
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         add_word(w);
         x ^= w;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      add_word(x);
`else
      if (x === 32'hx) $display("note: unexpected X in program");
`endif
   endtask

   function automatic logic [31:0] word_at(input int off);
      return {stim[off], stim[off+1], stim[off+2], stim[off+3]};
   endfunction

   task automatic model_stream();
      logic [31:0] n, w, x;
      x = '0;
      exp_addr.delete();
      exp_data.delete();
      exp_done  = 0;
      exp_error = 0;
      n = word_at(0);
      if (n == 0) begin
         exp_done = 1;
      end else if (n > MAX_WORDS) begin
         exp_error = 1;
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            w = word_at(4 + 4 * i);
            exp_addr.push_back(i);
            exp_data.push_back(w);
            x ^= w;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         w = word_at(4 + 4 * int'(n));
         exp_done  = (w == x);
         exp_error = !exp_done;
`else
         exp_done = (x !== 32'hx);
`endif
      end
   endtask

   task automatic do_reset();
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      start_up       = 1'b1;
      @(posedge clk);
      #1;
      start_up = 1'b0;
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      got_lat.delete();
      @(posedge clk);
      #1;
   endtask

   // Sends the first n bytes of stim; gap_pct is the chance of idle cycles
   // before each byte. ok=0 if any byte is not accepted within 50 cycles.
   task automatic send(input int n, input int gap_pct, output bit ok);
      bit acc;
      int waited;
      ok = 1;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < gap_pct) begin
            repeat ($urandom_range(3, 1)) begin
               bus.byte_valid = 1'b0;
               bus.byte_in    = 8'($urandom);
               @(posedge clk);
               #1;
            end
         end
         bus.byte_valid = 1'b1;
         bus.byte_in    = stim[i];
         acc    = 0;
         waited = 0;
         while (!acc && waited < 50) begin
            @(negedge clk);
            acc = bus.byte_ready;
            @(posedge clk);
            #1;
            waited++;
         end
         if (!acc) begin
            ok = 0;
            bus.byte_valid = 1'b0;
            return;
         end
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      start_up       = 1'b1;
      #1;
      n_cmp++;
      if ({bus.byte_ready, bus.imem_wr_en, bus.imem_addr, bus.imem_wr_data,
           cpu_start_up, busy, done, error} !== {3'b001, {ADDR_W{1'b0}}, 32'h0, 4'b1000} &&
          !(bus.byte_ready === 1'b0 && bus.imem_wr_en === 1'b0 && bus.imem_addr === '0 &&
            bus.imem_wr_data === '0 && cpu_start_up === 1'b1 && busy === 1'b0 &&
            done === 1'b0 && error === 1'b0)) begin
         n_mis++;
         $display("FAIL reset_values: got rdy=%b wr=%b addr=%0d data=%h cpu=%b busy=%b done=%b err=%b want 0 0 0 0 1 0 0 0",
                  bus.byte_ready, bus.imem_wr_en, bus.imem_addr, bus.imem_wr_data,
                  cpu_start_up, busy, done, error);
      end
      do_reset();
      n_cmp++;
      if (bus.byte_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL idle_ready: got %b want 1", bus.byte_ready);
      end
   endtask

   task automatic test_basic_load();
      bit ok;
      do_reset();
      stim.delete();
      add_word(32'd2);
      add_word(32'h2008_0005);
      add_word(32'h0000_000C);
`ifdef IMEM_LOADER_CHECKSUM_EN
      add_word(32'h2008_0005 ^ 32'h0000_000C);
`endif
      model_stream();
      send(stim.size(), 0, ok);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (!ok) begin n_mis++; $display("FAIL basic_timeout: got stalled want accepted"); end
      n_cmp++;
      if (got_data.size() != 2) begin
         n_mis++;
         $display("FAIL basic_nwrites: got %0d want 2", got_data.size());
      end
      foreach (exp_data[i]) if (i < got_data.size()) begin
         n_cmp++;
         if (got_addr[i] !== ADDR_W'(exp_addr[i]) || got_data[i] !== exp_data[i] || !got_lat[i]) begin
            n_mis++;
            $display("FAIL basic_write[%0d]: got addr %0d data %h lat_ok %0b want addr %0d data %h lat_ok 1",
                     i, got_addr[i], got_data[i], got_lat[i], exp_addr[i], exp_data[i]);
         end
      end
      n_cmp++;
      if (done !== 1'b1 || cpu_start_up !== 1'b0 || error !== 1'b0 || bus.byte_ready !== 1'b0 ||
          busy !== 1'b0) begin
         n_mis++;
         $display("FAIL basic_status: got done=%b cpu=%b err=%b rdy=%b busy=%b want 1 0 0 0 0",
                  done, cpu_start_up, error, bus.byte_ready, busy);
      end
   endtask

   task automatic test_zero_length();
      bit ok;
      do_reset();
      stim.delete();
      add_word(32'd0);
      send(stim.size(), 0, ok);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (!ok || got_data.size() != 0 || done !== 1'b1 || cpu_start_up !== 1'b0 || error !== 1'b0) begin
         n_mis++;
         $display("FAIL zero_len: got ok=%0b writes=%0d done=%b cpu=%b err=%b want 1 0 1 0 0",
                  ok, got_data.size(), done, cpu_start_up, error);
      end
   endtask

   task automatic test_oversize();
      logic [31:0] lens[2];
      bit ok;
      lens[0] = 32'd1025;
      lens[1] = 32'h8000_0001;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         stim.delete();
         add_word(lens[k]);
         model_stream();
         send(stim.size(), 0, ok);
         repeat (2) @(posedge clk);
         #1;
         n_cmp++;
         if (!ok || error !== exp_error || cpu_start_up !== 1'b1 || bus.byte_ready !== 1'b0 ||
             done !== 1'b0 || got_data.size() != 0) begin
            n_mis++;
            $display("FAIL oversize[%h]: got ok=%0b err=%b cpu=%b rdy=%b done=%b writes=%0d want 1 1 1 0 0 0",
                     lens[k], ok, error, cpu_start_up, bus.byte_ready, done, got_data.size());
         end
         // Further bytes are ignored while in ERROR.
         bus.byte_valid = 1'b1;
         bus.byte_in    = 8'hAA;
         repeat (5) @(posedge clk);
         #1;
         bus.byte_valid = 1'b0;
         n_cmp++;
         if (error !== 1'b1 || got_data.size() != 0 || cpu_start_up !== 1'b1) begin
            n_mis++;
            $display("FAIL oversize_absorb: got err=%b writes=%0d cpu=%b want 1 0 1",
                     error, got_data.size(), cpu_start_up);
         end
      end
   endtask

   // Valid held high throughout, including WRITE cycles: one word per 5 cycles.
   task automatic test_back_to_back();
      bit ok;
      do_reset();
      build_program(8);
      model_stream();
      send(stim.size(), 0, ok);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (!ok || got_data.size() != 8 || done !== exp_done) begin
         n_mis++;
         $display("FAIL b2b_count: got ok=%0b writes=%0d done=%b want 1 8 %b",
                  ok, got_data.size(), done, exp_done);
      end
      foreach (exp_data[i]) if (i < got_data.size()) begin
         n_cmp++;
         if (got_addr[i] !== ADDR_W'(exp_addr[i]) || got_data[i] !== exp_data[i] || !got_lat[i] ||
             (i > 0 && got_cyc[i] - got_cyc[i-1] != 5)) begin
            n_mis++;
            $display("FAIL b2b_write[%0d]: got addr %0d data %h lat_ok %0b spacing %0d want addr %0d data %h lat_ok 1 spacing 5",
                     i, got_addr[i], got_data[i], got_lat[i], (i > 0) ? got_cyc[i] - got_cyc[i-1] : 5,
                     exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_gaps();
      bit ok;
      int mism;
      for (int k = 0; k < 4; k++) begin
         do_reset();
         build_program((k == 0) ? 2 : int'($urandom_range(6, 1)));
         model_stream();
         send(stim.size(), 40, ok);
         repeat (4) @(posedge clk);
         #1;
         mism = 0;
         foreach (exp_data[i]) begin
            if (i >= got_data.size()) mism++;
            else if (got_addr[i] !== ADDR_W'(exp_addr[i]) || got_data[i] !== exp_data[i] || !got_lat[i])
               mism++;
         end
         n_cmp++;
         if (!ok || got_data.size() != exp_data.size() || mism != 0 || done !== exp_done ||
             error !== exp_error || cpu_start_up !== !exp_done) begin
            n_mis++;
            $display("FAIL gaps[%0d]: got ok=%0b writes=%0d bad=%0d done=%b err=%b cpu=%b want 1 %0d 0 %b %b %b",
                     k, ok, got_data.size(), mism, done, error, cpu_start_up,
                     exp_data.size(), exp_done, exp_error, !exp_done);
         end
      end
   endtask

   task automatic test_max_length();
      bit ok;
      int mism;
      do_reset();
      build_program(MAX_WORDS);
      model_stream();
      send(stim.size(), 0, ok);
      repeat (3) @(posedge clk);
      #1;
      mism = 0;
      foreach (exp_data[i]) begin
         if (i >= got_data.size()) mism++;
         else if (got_addr[i] !== ADDR_W'(exp_addr[i]) || got_data[i] !== exp_data[i]) mism++;
      end
      n_cmp++;
      if (!ok || got_data.size() != MAX_WORDS || mism != 0 || done !== 1'b1 || error !== 1'b0) begin
         n_mis++;
         $display("FAIL max_len: got ok=%0b writes=%0d bad=%0d done=%b err=%b want 1 %0d 0 1 0",
                  ok, got_data.size(), mism, done, error, MAX_WORDS);
      end
   endtask

   task automatic test_reset_mid_load();
      bit ok;
      do_reset();
      build_program(3);
      send(6, 0, ok);
      n_cmp++;
      if (!ok || busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL midload_pre: got ok=%0b busy=%b rdy=%b want 1 1 1", ok, busy, bus.byte_ready);
      end
      #1;
      start_up = 1'b1;
      #1;
      n_cmp++;
      if (cpu_start_up !== 1'b1 || bus.byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          error !== 1'b0 || bus.imem_wr_en !== 1'b0 || bus.imem_addr !== '0 ||
          bus.imem_wr_data !== '0) begin
         n_mis++;
         $display("FAIL midload_async: got cpu=%b rdy=%b busy=%b done=%b err=%b wr=%b addr=%0d data=%h want 1 0 0 0 0 0 0 0",
                  cpu_start_up, bus.byte_ready, busy, done, error, bus.imem_wr_en,
                  bus.imem_addr, bus.imem_wr_data);
      end
      do_reset();
      build_program(1);
      model_stream();
      send(stim.size(), 20, ok);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (!ok || got_data.size() != 1 || done !== 1'b1 ||
          (got_data.size() == 1 && (got_addr[0] !== '0 || got_data[0] !== exp_data[0]))) begin
         n_mis++;
         $display("FAIL midload_fresh: got ok=%0b writes=%0d done=%b addr=%0d data=%h want 1 1 1 0 %h",
                  ok, got_data.size(), done, (got_addr.size() > 0) ? got_addr[0] : '0,
                  (got_data.size() > 0) ? got_data[0] : '0, exp_data[0]);
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [31:0] cs[2];
      bit ok;
      cs[0] = 32'h3333_3333;
      cs[1] = 32'h3333_3332;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         stim.delete();
         add_word(32'd2);
         add_word(32'h1111_1111);
         add_word(32'h2222_2222);
         add_word(cs[k]);
         model_stream();
         send(stim.size(), 0, ok);
         repeat (3) @(posedge clk);
         #1;
         n_cmp++;
         if (!ok || got_data.size() != 2 || done !== exp_done || error !== exp_error ||
             cpu_start_up !== !exp_done || bus.byte_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL checksum[%h]: got ok=%0b writes=%0d done=%b err=%b cpu=%b rdy=%b want 1 2 %b %b %b 0",
                     cs[k], ok, got_data.size(), done, error, cpu_start_up, bus.byte_ready,
                     exp_done, exp_error, !exp_done);
         end
      end
   endtask
`endif

   initial begin
      start_up       = 1'b1;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      test_reset();
      test_basic_load();
      test_zero_length();
      test_oversize();
      test_back_to_back();
      test_gaps();
      test_max_length();
      test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
